// File: rtl/tmr_seq_neuron.sv
// Sequential neuron: P lanes per cycle of triplicated Q-format multiplies with
// per-weight CRC-8 checking, a triplicated saturating accumulator, and a
// valid/ready front and back end.
module tmr_seq_neuron #(
  parameter int M        = 16,
  parameter int P        = 4,
  parameter int n        = 32,
  parameter int cl       = 8,
  parameter int intbits  = 12,
  parameter int fracbits = 20
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [M*n-1:0]          X,
  input  logic [M*(n+cl)-1:0]     Wcrc,
  input  logic [2:0]              fi_en,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [n-1:0]            H,
  output logic                    invalid,
  output logic                    rfflag,
  output logic                    ovf
);

  localparam int NCH = M / P;
  localparam int KW  = (NCH > 1) ? $clog2(NCH) : 1;
  localparam int SW  = n + $clog2(P) + 1;
  localparam int WF  = n + cl;
  localparam logic [cl-1:0] POLY = cl'(7);

  if (intbits + fracbits != n) begin : g_bad_qformat
    $error("intbits + fracbits must equal n");
  end

  // Handshakes: a transfer happens on a rising edge where valid && ready are
  // both high; valid must not depend on ready, and data is held while valid
  // is high and ready is low.
  typedef enum logic [1:0] {IDLE, ACCUM, DONE} state_t;

  state_t             state_q, state_d;
  logic [KW-1:0]      k_q;
  logic [M*n-1:0]     x_q;
  logic [M*WF-1:0]    w_q;
  logic [n-1:0]       acc_r [3];
  logic [n-1:0]       acc_v;
  logic               acc_err;
  logic [n-1:0]       h_q;
  logic               invalid_q, rfflag_q, ovf_q;

  logic [n-1:0]       rep [P][3];
  logic [n-1:0]       vote [P];
  logic               prod_ovf, tmr_err, crc_err, acc_ovf;
  logic [SW-1:0]      sum;
  logic [n-1:0]       sat_sum;

  function automatic logic [cl-1:0] crc_calc(input logic [n-1:0] d);
    logic [cl-1:0] c;
    logic          fb;
    c = '0;
    for (int i = n - 1; i >= 0; i--) begin
      fb = c[cl-1] ^ d[i];
      c  = c << 1;
      if (fb) c = c ^ POLY;
    end
    return c;
  endfunction

  // Returns {saturated, value}: product rescaled by fracbits, clipped to n bits.
  function automatic logic [n:0] mul_sat(input logic [n-1:0] a, input logic [n-1:0] b);
    logic signed [2*n-1:0] p;
    logic signed [2*n-1:0] s;
    p = $signed(a) * $signed(b);
    s = p >>> fracbits;
    if (&s[2*n-1:n-1] || ~|s[2*n-1:n-1])
      return {1'b0, s[n-1:0]};
    else if (s[2*n-1])
      return {1'b1, 1'b1, {(n-1){1'b0}}};
    else
      return {1'b1, 1'b0, {(n-1){1'b1}}};
  endfunction

  assign acc_v   = (acc_r[0] & acc_r[1]) | (acc_r[0] & acc_r[2]) | (acc_r[1] & acc_r[2]);
  assign acc_err = (acc_r[0] != acc_r[1]) || (acc_r[0] != acc_r[2]);

  always_comb begin
    int            idx;
    logic [n-1:0]  xl;
    logic [WF-1:0] wf;
    logic [n:0]    m;
    idx      = 0;
    xl       = '0;
    wf       = '0;
    m        = '0;
    rep      = '{default: '0};
    vote     = '{default: '0};
    prod_ovf = 1'b0;
    tmr_err  = 1'b0;
    crc_err  = 1'b0;
    sum      = {{(SW-n){acc_v[n-1]}}, acc_v};
    for (int l = 0; l < P; l++) begin
      idx = int'(k_q) * P + l;
      xl  = x_q[idx*n +: n];
      wf  = w_q[idx*WF +: WF];
      if (crc_calc(wf[WF-1:cl]) != wf[cl-1:0]) crc_err = 1'b1;
      for (int r = 0; r < 3; r++) begin
        m         = mul_sat(xl, wf[WF-1:cl]);
        rep[l][r] = m[n-1:0];
        if (l == 0) rep[l][r][0] = m[0] ^ fi_en[r];
        prod_ovf  = prod_ovf | m[n];
      end
      vote[l] = (rep[l][0] & rep[l][1]) | (rep[l][0] & rep[l][2]) | (rep[l][1] & rep[l][2]);
      if ((rep[l][0] != rep[l][1]) || (rep[l][0] != rep[l][2])) tmr_err = 1'b1;
      sum = sum + {{(SW-n){vote[l][n-1]}}, vote[l]};
    end
    // Fits when every bit above the result's sign bit matches it.
    if (&sum[SW-1:n-1] || ~|sum[SW-1:n-1]) begin
      sat_sum = sum[n-1:0];
      acc_ovf = 1'b0;
    end else begin
      sat_sum = sum[SW-1] ? {1'b1, {(n-1){1'b0}}} : {1'b0, {(n-1){1'b1}}};
      acc_ovf = 1'b1;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (in_valid) state_d = ACCUM;
      ACCUM:   if (k_q == KW'(NCH - 1)) state_d = DONE;
      DONE:    if (out_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      k_q       <= '0;
      x_q       <= '0;
      w_q       <= '0;
      acc_r     <= '{default: '0};
      h_q       <= '0;
      invalid_q <= 1'b0;
      rfflag_q  <= 1'b0;
      ovf_q     <= 1'b0;
    end else begin
      state_q <= state_d;
      case (state_q)
        IDLE: if (in_valid) begin
          x_q       <= X;
          w_q       <= Wcrc;
          acc_r     <= '{default: '0};
          k_q       <= '0;
          invalid_q <= 1'b0;
          rfflag_q  <= 1'b0;
          ovf_q     <= 1'b0;
        end
        ACCUM: begin
          for (int r = 0; r < 3; r++) acc_r[r] <= sat_sum;
          k_q       <= k_q + 1'b1;
          invalid_q <= invalid_q | tmr_err | acc_err;
          rfflag_q  <= rfflag_q | crc_err;
          ovf_q     <= ovf_q | prod_ovf | acc_ovf;
          if (k_q == KW'(NCH - 1)) h_q <= sat_sum;
        end
        default: ;
      endcase
    end
  end

  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == DONE);
  assign H         = h_q;
  assign invalid   = invalid_q;
  assign rfflag    = rfflag_q;
  assign ovf       = ovf_q;

endmodule
